// File: rtl/lsb_mem_ctrl.sv
// lsb_mem_ctrl: byte-serial data-memory responder for the load/store buffer.
// Runs one load or store at a time over the 8-bit RAM/IO port and pulses completion back to the LSB.
module lsb_mem_ctrl #(
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] IO_BASE    = ADDR_WIDTH'(32'h00030000),
  parameter logic [6:0]            S_TYPE     = 7'b0100011
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy,
  input  logic                  rob_clear,
  input  logic                  in_lsb_ready,
  input  logic [2:0]            op_in,
  input  logic [6:0]            instr_type_in,
  input  logic [ADDR_WIDTH-1:0] data_addr_in,
  input  logic [31:0]           data_in,
  output logic                  welcome_lsb,
  output logic                  cache_ready,
  output logic [6:0]            cache_instr_type,
  output logic [31:0]           cache_data_out,
  input  logic [7:0]            mem_din,
  output logic [7:0]            mem_dout,
  output logic [ADDR_WIDTH-1:0] mem_a,
  output logic                  mem_wr,
  input  logic                  io_buffer_full
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, IO_WAIT} state_e;

  state_e                state_q;
  logic [1:0]            cnt_q;
  logic [2:0]            op_q;
  logic [6:0]            type_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           data_q;
  logic [31:0]           word_q;
  logic                  welcome_q;
  logic                  cache_ready_q;
  logic [6:0]            cache_type_q;
  logic [31:0]           cache_data_q;
  logic [ADDR_WIDTH-1:0] mem_a_q;
  logic [7:0]            mem_dout_q;
  logic                  mem_wr_q;

  logic [1:0]            last_cnt_d;
  logic [1:0]            cnt_inc_d;
  logic [ADDR_WIDTH-1:0] addr_inc_d;
  logic [7:0]            byte_d;
  logic [31:0]           word_d;
  logic [31:0]           ext_d;
  logic                  is_io_d;

  always_comb begin
    case (op_q[1:0])
      2'b00:   last_cnt_d = 2'd0;
      2'b01:   last_cnt_d = 2'd1;
      default: last_cnt_d = 2'd3;
    endcase
    cnt_inc_d  = cnt_q + 2'd1;
    addr_inc_d = addr_q + ADDR_WIDTH'(cnt_inc_d);
    byte_d     = 8'(data_q >> {cnt_inc_d, 3'b000});
    // Little-endian assembly: the byte on mem_din lands at lane cnt_q.
    word_d = word_q;
    word_d[{cnt_q, 3'b000} +: 8] = mem_din;
    case (op_q[1:0])
      2'b00:   ext_d = {{24{word_d[7]  & ~op_q[2]}}, word_d[7:0]};
      2'b01:   ext_d = {{16{word_d[15] & ~op_q[2]}}, word_d[15:0]};
      default: ext_d = word_d;
    endcase
    is_io_d = (data_addr_in == IO_BASE) || (data_addr_in == IO_BASE + ADDR_WIDTH'(4));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      op_q          <= '0;
      type_q        <= '0;
      addr_q        <= '0;
      data_q        <= '0;
      word_q        <= '0;
      welcome_q     <= 1'b1;
      cache_ready_q <= 1'b0;
      cache_type_q  <= '0;
      cache_data_q  <= '0;
      mem_a_q       <= '0;
      mem_dout_q    <= '0;
      mem_wr_q      <= 1'b0;
    end else if (rdy) begin
      cache_ready_q <= 1'b0;
      case (state_q)
        IDLE: begin
          welcome_q <= 1'b1;
          if (welcome_q && in_lsb_ready && !rob_clear) begin
            op_q      <= op_in;
            type_q    <= instr_type_in;
            addr_q    <= data_addr_in;
            data_q    <= data_in;
            word_q    <= '0;
            cnt_q     <= '0;
            welcome_q <= 1'b0;
            mem_a_q   <= data_addr_in;
            if (instr_type_in == S_TYPE) begin
              if (is_io_d && io_buffer_full) begin
                state_q  <= IO_WAIT;
                mem_wr_q <= 1'b0;
              end else begin
                state_q    <= WRITE;
                mem_wr_q   <= 1'b1;
                mem_dout_q <= data_in[7:0];
              end
            end else begin
              state_q  <= READ;
              mem_wr_q <= 1'b0;
            end
          end
        end
        READ: begin
          // Loads are speculative: a flush drops them without a completion pulse.
          if (rob_clear) begin
            state_q   <= IDLE;
            welcome_q <= 1'b1;
            mem_wr_q  <= 1'b0;
          end else begin
            word_q <= word_d;
            if (cnt_q == last_cnt_d) begin
              state_q       <= IDLE;
              cache_ready_q <= 1'b1;
              cache_type_q  <= type_q;
              cache_data_q  <= ext_d;
            end else begin
              cnt_q   <= cnt_inc_d;
              mem_a_q <= addr_inc_d;
            end
          end
        end
        WRITE: begin
          if (cnt_q == last_cnt_d) begin
            state_q       <= IDLE;
            mem_wr_q      <= 1'b0;
            cache_ready_q <= 1'b1;
            cache_type_q  <= type_q;
            cache_data_q  <= '0;
          end else begin
            cnt_q      <= cnt_inc_d;
            mem_a_q    <= addr_inc_d;
            mem_dout_q <= byte_d;
          end
        end
        IO_WAIT: begin
          if (!io_buffer_full) begin
            state_q    <= WRITE;
            mem_wr_q   <= 1'b1;
            mem_dout_q <= data_q[7:0];
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Gating the strobe while frozen keeps a held byte from being written on every stalled cycle.
  assign mem_wr           = mem_wr_q & rdy;
  assign mem_a            = mem_a_q;
  assign mem_dout         = mem_dout_q;
  assign welcome_lsb      = welcome_q;
  assign cache_ready      = cache_ready_q;
  assign cache_instr_type = cache_type_q;
  assign cache_data_out   = cache_data_q;

endmodule

// File: tb/tb_lsb_mem_ctrl.sv
// Self-checking bench for lsb_mem_ctrl: directed scenarios plus randomized requests
// compared against a byte-array memory model and plain-arithmetic load extension.
module tb_lsb_mem_ctrl;

  localparam logic [6:0]  LD_T    = 7'b0000011;
  localparam logic [6:0]  S_T     = 7'b0100011;
  localparam logic [31:0] IO_BASE = 32'h00030000;

  logic        clk = 1'b0;
  logic        rst, rdy, rob_clear, in_lsb_ready, io_buffer_full;
  logic [2:0]  op_in;
  logic [6:0]  instr_type_in;
  logic [31:0] data_addr_in, data_in;
  logic        welcome_lsb, cache_ready, mem_wr;
  logic [6:0]  cache_instr_type;
  logic [31:0] cache_data_out, mem_a;
  logic [7:0]  mem_din, mem_dout;

  logic [7:0]  ram [0:4095];
  logic [39:0] wr_log [$];
  logic [31:0] addr_log [$];
  int total = 0;
  int bad = 0;

  typedef struct {
    logic        done;
    int          lat;
    logic [31:0] rdata;
    logic [6:0]  rtype;
    logic        wel_accept;
    logic        wel_at_ready;
    logic        ready_after;
    logic        wel_after;
    logic        wel_clear;
    int          wr_base;
  } res_t;

  lsb_mem_ctrl dut (
    .clk(clk), .rst(rst), .rdy(rdy), .rob_clear(rob_clear), .in_lsb_ready(in_lsb_ready),
    .op_in(op_in), .instr_type_in(instr_type_in), .data_addr_in(data_addr_in), .data_in(data_in),
    .welcome_lsb(welcome_lsb), .cache_ready(cache_ready), .cache_instr_type(cache_instr_type),
    .cache_data_out(cache_data_out), .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a),
    .mem_wr(mem_wr), .io_buffer_full(io_buffer_full)
  );

  always #5 clk = ~clk;

  assign mem_din = ram[mem_a[11:0]];

  always @(posedge clk) begin
    if (mem_wr === 1'b1) wr_log.push_back({mem_a, mem_dout});
  end

  function automatic int nbytes(input logic [2:0] op);
    case (op[1:0])
      2'b00:   return 1;
      2'b01:   return 2;
      default: return 4;
    endcase
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] op, input logic [31:0] addr);
    logic [31:0] v;
    logic [31:0] a;
    v = 0;
    for (int k = 0; k < nbytes(op); k++) begin
      a = addr + 32'(k);
      v = v + (32'(ram[a[11:0]]) << (8 * k));
    end
    if (op == 3'b000 && v >= 32'd128)   v = v - 32'd256;
    if (op == 3'b001 && v >= 32'd32768) v = v - 32'd65536;
    return v;
  endfunction

  task automatic model_store(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] d);
    logic [31:0] a;
    for (int k = 0; k < nbytes(op); k++) begin
      a = addr + 32'(k);
      ram[a[11:0]] = 8'(d >> (8 * k));
    end
  endtask

  task automatic run_req(input logic [2:0] op, input logic st, input logic [31:0] addr,
                         input logic [31:0] wdata, input int stall_at, input int stall_len,
                         input int clear_at, input int full_len, output res_t r);
    int guard;
    r.done = 0; r.lat = 0; r.rdata = 0; r.rtype = 0; r.wel_accept = 0; r.wel_at_ready = 0;
    r.ready_after = 0; r.wel_after = 0; r.wel_clear = 0;
    guard = 0;
    while (welcome_lsb !== 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    total++;
    if (welcome_lsb !== 1'b1) begin
      bad++;
      $display("FAIL welcome_wait got=%b want=1", welcome_lsb);
    end
    r.wr_base = wr_log.size();
    addr_log.delete();
    in_lsb_ready   = 1'b1;
    op_in          = op;
    instr_type_in  = st ? S_T : LD_T;
    data_addr_in   = addr;
    data_in        = wdata;
    io_buffer_full = (full_len > 0);
    @(negedge clk);
    r.wel_accept  = welcome_lsb;
    in_lsb_ready  = 1'b0;
    op_in         = 3'($urandom);
    data_addr_in  = $urandom;
    data_in       = $urandom;
    instr_type_in = 7'($urandom);
    for (int n = 1; n <= 40 && !r.done; n++) begin
      addr_log.push_back(mem_a);
      if (n >= full_len) io_buffer_full = 1'b0;
      if (n == stall_at) rdy = 1'b0;
      if (n == stall_at + stall_len) rdy = 1'b1;
      rob_clear = (n == clear_at);
      @(negedge clk);
      if (n == clear_at) r.wel_clear = welcome_lsb;
      if (cache_ready === 1'b1) begin
        r.done = 1; r.lat = n; r.rdata = cache_data_out; r.rtype = cache_instr_type;
        r.wel_at_ready = welcome_lsb;
      end
    end
    rob_clear = 1'b0;
    rdy = 1'b1;
    io_buffer_full = 1'b0;
    @(negedge clk);
    r.ready_after = cache_ready;
    r.wel_after   = welcome_lsb;
    if (st) model_store(op, addr, wdata);
    $display("txn op=%0d st=%0d addr=%h wdata=%h done=%0d lat=%0d data=%h writes=%0d",
             op, st, addr, wdata, r.done, r.lat, r.rdata, wr_log.size() - r.wr_base);
  endtask

  task automatic test_reset();
    rst = 1'b1; rdy = 1'b1; rob_clear = 0; in_lsb_ready = 0; io_buffer_full = 0;
    op_in = 0; instr_type_in = 0; data_addr_in = 0; data_in = 0;
    repeat (3) @(negedge clk);
    total++; if (welcome_lsb !== 1'b1) begin bad++; $display("FAIL rst_welcome got=%b want=1", welcome_lsb); end
    total++; if (cache_ready !== 1'b0) begin bad++; $display("FAIL rst_ready got=%b want=0", cache_ready); end
    total++; if (cache_instr_type !== 7'd0) begin bad++; $display("FAIL rst_type got=%h want=0", cache_instr_type); end
    total++; if (cache_data_out !== 32'd0) begin bad++; $display("FAIL rst_data got=%h want=0", cache_data_out); end
    total++; if (mem_a !== 32'd0 || mem_dout !== 8'd0 || mem_wr !== 1'b0) begin
      bad++; $display("FAIL rst_mem got=a:%h d:%h wr:%b want=0", mem_a, mem_dout, mem_wr);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_load_word();
    res_t r;
    ram[12'h100] = 8'h78; ram[12'h101] = 8'h56; ram[12'h102] = 8'h34; ram[12'h103] = 8'h12;
    run_req(3'b010, 0, 32'h100, 32'h0, 0, 0, 0, 0, r);
    total++; if (r.wel_accept !== 1'b0) begin bad++; $display("FAIL lw_welcome_busy got=%b want=0", r.wel_accept); end
    total++; if (r.done !== 1'b1 || r.lat != 4) begin bad++; $display("FAIL lw_latency got=%0d want=4", r.lat); end
    total++; if (r.rdata !== 32'h12345678) begin bad++; $display("FAIL lw_data got=%h want=12345678", r.rdata); end
    total++; if (r.rtype !== LD_T) begin bad++; $display("FAIL lw_type got=%h want=%h", r.rtype, LD_T); end
    for (int k = 0; k < 4; k++) begin
      total++;
      if (addr_log[k] !== 32'h100 + 32'(k)) begin
        bad++; $display("FAIL lw_addr%0d got=%h want=%h", k, addr_log[k], 32'h100 + 32'(k));
      end
    end
    total++; if (r.wel_at_ready !== 1'b0) begin bad++; $display("FAIL lw_welcome_at_ready got=%b want=0", r.wel_at_ready); end
    total++; if (r.ready_after !== 1'b0 || r.wel_after !== 1'b1) begin
      bad++; $display("FAIL lw_after got=rdy:%b wel:%b want=rdy:0 wel:1", r.ready_after, r.wel_after);
    end
  endtask

  task automatic test_load_ext();
    res_t r;
    ram[12'h200] = 8'h80;
    ram[12'h210] = 8'h01; ram[12'h211] = 8'h80;
    run_req(3'b000, 0, 32'h200, 32'h0, 0, 0, 0, 0, r);
    total++; if (r.rdata !== 32'hFFFFFF80 || r.lat != 1) begin bad++; $display("FAIL lb_sign got=%h lat=%0d want=ffffff80 lat=1", r.rdata, r.lat); end
    run_req(3'b100, 0, 32'h200, 32'h0, 0, 0, 0, 0, r);
    total++; if (r.rdata !== 32'h00000080) begin bad++; $display("FAIL lbu_zero got=%h want=00000080", r.rdata); end
    run_req(3'b001, 0, 32'h210, 32'h0, 0, 0, 0, 0, r);
    total++; if (r.rdata !== 32'hFFFF8001 || r.lat != 2) begin bad++; $display("FAIL lh_sign got=%h lat=%0d want=ffff8001 lat=2", r.rdata, r.lat); end
    run_req(3'b101, 0, 32'h210, 32'h0, 0, 0, 0, 0, r);
    total++; if (r.rdata !== 32'h00008001) begin bad++; $display("FAIL lhu_zero got=%h want=00008001", r.rdata); end
  endtask

  task automatic test_store_word();
    res_t r;
    logic [39:0] exp;
    run_req(3'b010, 1, 32'h300, 32'hDEADBEEF, 0, 0, 0, 0, r);
    total++; if (r.done !== 1'b1 || r.lat != 4) begin bad++; $display("FAIL sw_latency got=%0d want=4", r.lat); end
    total++; if (r.rdata !== 32'd0 || r.rtype !== S_T) begin bad++; $display("FAIL sw_result got=%h/%h want=0/%h", r.rdata, r.rtype, S_T); end
    total++; if (wr_log.size() - r.wr_base != 4) begin bad++; $display("FAIL sw_count got=%0d want=4", wr_log.size() - r.wr_base); end
    for (int k = 0; k < 4 && r.wr_base + k < wr_log.size(); k++) begin
      exp = {32'h300 + 32'(k), 8'(32'hDEADBEEF >> (8 * k))};
      total++; if (wr_log[r.wr_base + k] !== exp) begin bad++; $display("FAIL sw_byte%0d got=%h want=%h", k, wr_log[r.wr_base + k], exp); end
    end
  endtask

  task automatic test_io_wait();
    res_t r;
    run_req(3'b000, 1, IO_BASE, 32'h00000041, 0, 0, 0, 5, r);
    total++; if (r.done !== 1'b1 || r.lat != 6) begin bad++; $display("FAIL io_sb_latency got=%0d want=6", r.lat); end
    total++; if (wr_log.size() - r.wr_base != 1) begin bad++; $display("FAIL io_sb_count got=%0d want=1", wr_log.size() - r.wr_base); end
    else begin
      total++; if (wr_log[r.wr_base] !== {IO_BASE, 8'h41}) begin bad++; $display("FAIL io_sb_byte got=%h want=%h", wr_log[r.wr_base], {IO_BASE, 8'h41}); end
    end
    run_req(3'b000, 1, IO_BASE + 32'd8, 32'h00000042, 0, 0, 0, 5, r);
    total++; if (r.lat != 1) begin bad++; $display("FAIL io_nonport_latency got=%0d want=1", r.lat); end
  endtask

  task automatic test_rob_clear();
    res_t r;
    run_req(3'b010, 0, 32'h100, 32'h0, 0, 0, 3, 0, r);
    total++; if (r.done !== 1'b0) begin bad++; $display("FAIL clr_lw_ready got=%b want=0", r.done); end
    total++; if (r.wel_clear !== 1'b1) begin bad++; $display("FAIL clr_lw_welcome got=%b want=1", r.wel_clear); end
    run_req(3'b010, 1, 32'h300, 32'hCAFEF00D, 0, 0, 2, 0, r);
    total++; if (r.done !== 1'b1 || r.lat != 4) begin bad++; $display("FAIL clr_sw_latency got=%0d want=4", r.lat); end
    total++; if (wr_log.size() - r.wr_base != 4) begin bad++; $display("FAIL clr_sw_count got=%0d want=4", wr_log.size() - r.wr_base); end
    // Request presented together with a flush must be refused.
    @(negedge clk);
    in_lsb_ready = 1'b1; rob_clear = 1'b1; op_in = 3'b010; instr_type_in = LD_T; data_addr_in = 32'h100;
    @(negedge clk);
    in_lsb_ready = 1'b0; rob_clear = 1'b0;
    total++; if (welcome_lsb !== 1'b1) begin bad++; $display("FAIL clr_same_cycle_accept got=%b want=1", welcome_lsb); end
    repeat (5) @(negedge clk);
    total++; if (welcome_lsb !== 1'b1 || cache_ready !== 1'b0) begin
      bad++; $display("FAIL clr_same_cycle_idle got=wel:%b rdy:%b want=wel:1 rdy:0", welcome_lsb, cache_ready);
    end
  endtask

  task automatic test_rdy_stall();
    res_t r;
    int cnt;
    run_req(3'b010, 0, 32'h100, 32'h0, 2, 3, 0, 0, r);
    total++; if (r.lat != 7 || r.rdata !== model_load(3'b010, 32'h100)) begin
      bad++; $display("FAIL stall_lw got=%h lat=%0d want=%h lat=7", r.rdata, r.lat, model_load(3'b010, 32'h100));
    end
    run_req(3'b010, 1, 32'h300, 32'h01234567, 2, 3, 0, 0, r);
    cnt = wr_log.size() - r.wr_base;
    total++; if (r.lat != 7 || cnt != 4) begin bad++; $display("FAIL stall_sw got=lat:%0d writes:%0d want=lat:7 writes:4", r.lat, cnt); end
    for (int k = 0; k < 4 && k < cnt; k++) begin
      total++;
      if (wr_log[r.wr_base + k] !== {32'h300 + 32'(k), 8'(32'h01234567 >> (8 * k))}) begin
        bad++; $display("FAIL stall_sw_byte%0d got=%h", k, wr_log[r.wr_base + k]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int base;
    @(negedge clk);
    base = wr_log.size();
    in_lsb_ready = 1'b1; op_in = 3'b010; instr_type_in = S_T; data_addr_in = 32'h400; data_in = 32'h11223344;
    @(negedge clk);
    in_lsb_ready = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    total++; if (mem_wr !== 1'b0 || mem_a !== 32'd0 || welcome_lsb !== 1'b1 || cache_ready !== 1'b0) begin
      bad++; $display("FAIL rst_mid got=wr:%b a:%h wel:%b rdy:%b want=0/0/1/0", mem_wr, mem_a, welcome_lsb, cache_ready);
    end
    rst = 1'b0;
    ram[12'h400] = 8'h44; ram[12'h401] = 8'h33;
    repeat (6) @(negedge clk);
    total++; if (wr_log.size() - base != 2) begin bad++; $display("FAIL rst_mid_writes got=%0d want=2", wr_log.size() - base); end
  endtask

  task automatic test_random();
    res_t r;
    logic [2:0] op;
    logic st, io_wait;
    logic [31:0] addr, wdata, exp_data;
    int n, full_len, w, stall_at, stall_len, cnt;
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 4))
        0: op = 3'b000;
        1: op = 3'b001;
        2: op = 3'b010;
        3: op = 3'b100;
        default: op = 3'b101;
      endcase
      st = 1'($urandom_range(0, 1));
      if (st) op[2] = 1'b0;
      case ($urandom_range(0, 4))
        0: addr = IO_BASE;
        1: addr = IO_BASE + 32'd4;
        2: addr = IO_BASE + 32'd8;
        3: addr = 32'hFFFFFFFC + 32'($urandom_range(0, 3));
        default: addr = 32'($urandom_range(0, 4095));
      endcase
      wdata = $urandom;
      n = nbytes(op);
      io_wait = st && (addr == IO_BASE || addr == IO_BASE + 32'd4);
      full_len = $urandom_range(0, 1) ? $urandom_range(1, 4) : 0;
      w = (io_wait && full_len > 0) ? full_len : 0;
      if ($urandom_range(0, 1) == 1) begin
        stall_at = w + $urandom_range(1, n);
        stall_len = $urandom_range(1, 3);
      end else begin
        stall_at = 0;
        stall_len = 0;
      end
      exp_data = st ? 32'd0 : model_load(op, addr);
      run_req(op, st, addr, wdata, stall_at, stall_len, 0, full_len, r);
      total++; if (r.done !== 1'b1 || r.lat != w + n + stall_len) begin
        bad++; $display("FAIL rnd%0d_latency got=%0d want=%0d", i, r.lat, w + n + stall_len);
      end
      total++; if (r.rdata !== exp_data || r.rtype !== (st ? S_T : LD_T)) begin
        bad++; $display("FAIL rnd%0d_result got=%h/%h want=%h/%h", i, r.rdata, r.rtype, exp_data, st ? S_T : LD_T);
      end
      total++; if (r.ready_after !== 1'b0 || r.wel_after !== 1'b1) begin
        bad++; $display("FAIL rnd%0d_pulse got=rdy:%b wel:%b want=rdy:0 wel:1", i, r.ready_after, r.wel_after);
      end
      cnt = wr_log.size() - r.wr_base;
      total++; if (cnt != (st ? n : 0)) begin bad++; $display("FAIL rnd%0d_wcount got=%0d want=%0d", i, cnt, st ? n : 0); end
      for (int k = 0; k < cnt && k < n && st; k++) begin
        total++;
        if (wr_log[r.wr_base + k] !== {addr + 32'(k), 8'(wdata >> (8 * k))}) begin
          bad++; $display("FAIL rnd%0d_byte%0d got=%h want=%h", i, k, wr_log[r.wr_base + k], {addr + 32'(k), 8'(wdata >> (8 * k))});
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) ram[i] = 8'($urandom);
    test_reset();
    test_load_word();
    test_load_ext();
    test_store_word();
    test_io_wait();
    test_rob_clear();
    test_rdy_stall();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL global_timeout got=running want=finished");
    $fatal(1, "timeout");
  end

endmodule
